// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_ctrl_pkg
//  Description : Shared types and constants for the Wishbone 512x32 SRAM
//                controller. Holds the controller state encoding and the
//                RAM geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_ctrl_pkg;

    localparam int RAM_DEPTH = 512;
    localparam int RAM_AW    = 9;

    // FILL : zero/pattern fill of every word after reset
    // IDLE : waiting for a bus request
    // RD   : read-data capture cycle (only used when read data is registered)
    // ACK  : acknowledge cycle, no new request accepted here
    typedef enum logic [1:0] {
        FILL = 2'd0,
        IDLE = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } ram_ctrl_state_e;

endpackage : ram_ctrl_pkg
`default_nettype wire

// File: rtl/wb_ram512x32_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wb_ram512x32_ctrl
//  Description : Wishbone-classic responder in front of a 512x32 byte-writable
//                synchronous SRAM wrapper. After reset it writes FILL_VAL to
//                every word, then serves single-beat reads and byte-masked
//                writes with a one-cycle acknowledge (two cycles for reads
//                when REG_RDATA = 1).
//
//  Parameters  : FILL_EN   - 1: run the fill after reset, 0: start in IDLE
//                FILL_VAL  - word written to every address during the fill
//                REG_RDATA - 1: register RAM read data before the ack
//
//  Ports       : clk_i, rst_i             clock / synchronous active-high reset
//                wb_cyc_i, wb_stb_i       bus cycle / strobe
//                wb_we_i, wb_sel_i        write enable / byte lanes
//                wb_adr_i, wb_dat_i       word address / write data
//                wb_dat_o, wb_ack_o       read data (0 unless acked) / ack
//                init_done_o              fill complete
//                ram_wen_o, ram_sel_o     RAM write enable / byte select
//                ram_adr_o, ram_dat_o     RAM address / write data
//                ram_dat_i                RAM read data (one cycle after addr)
//
//  Revision    : 1.0  initial release
// ============================================================================
module wb_ram512x32_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter bit          FILL_EN   = 1'b1,
    parameter logic [31:0] FILL_VAL  = 32'h0000_0000,
    parameter bit          REG_RDATA = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [RAM_AW-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              init_done_o,
    output logic              ram_wen_o,
    output logic [3:0]        ram_sel_o,
    output logic [RAM_AW-1:0] ram_adr_o,
    output logic [31:0]       ram_dat_o,
    input  logic [31:0]       ram_dat_i
);

    localparam logic [RAM_AW-1:0] c_last_addr   = RAM_AW'(RAM_DEPTH - 1);
    localparam ram_ctrl_state_e   c_reset_state = FILL_EN ? FILL : IDLE;

    ram_ctrl_state_e   r_state;
    logic [RAM_AW-1:0] r_fill_cnt;
    logic [RAM_AW-1:0] r_adr;
    logic              r_is_read;
    logic              r_init_done;
    logic [31:0]       r_rdata;

    logic              w_req;

    assign w_req       = wb_cyc_i & wb_stb_i;
    assign init_done_o = r_init_done;

    // ------------------------------------------------------------------------
    // State machine and holding registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_reset_state;
            r_fill_cnt  <= '0;
            r_adr       <= '0;
            r_is_read   <= 1'b0;
            r_rdata     <= '0;
            r_init_done <= !FILL_EN;
        end else begin
            case (r_state)
                FILL: begin
                    // Counter parks at the last address; it never wraps.
                    if (r_fill_cnt == c_last_addr) begin
                        r_state     <= IDLE;
                        r_init_done <= 1'b1;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (w_req) begin
                        // Access type and address are frozen here so that a
                        // changing bus in RD/ACK cannot alter the transfer.
                        r_adr     <= wb_adr_i;
                        r_is_read <= !wb_we_i;
                        r_state   <= (!wb_we_i && REG_RDATA) ? RD : ACK;
                    end
                end
                RD: begin
                    r_rdata <= ram_dat_i;
                    // A master that gives up the cycle here gets no ack.
                    r_state <= wb_cyc_i ? ACK : IDLE;
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= c_reset_state;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // RAM and bus outputs. These follow the bus combinationally in IDLE so a
    // write commits on the same edge that samples the request; everything is
    // forced quiet while reset is asserted.
    // ------------------------------------------------------------------------
    always_comb begin
        ram_wen_o = 1'b0;
        ram_sel_o = 4'h0;
        ram_adr_o = wb_adr_i;
        ram_dat_o = wb_dat_i;
        wb_ack_o  = 1'b0;
        wb_dat_o  = 32'h0;
        if (!rst_i) begin
            case (r_state)
                FILL: begin
                    ram_wen_o = 1'b1;
                    ram_sel_o = 4'hF;
                    ram_adr_o = r_fill_cnt;
                    ram_dat_o = FILL_VAL;
                end
                IDLE: begin
                    if (w_req) begin
                        ram_sel_o = wb_sel_i;
                        ram_wen_o = wb_we_i & (|wb_sel_i);
                    end
                end
                RD: begin
                    // Hold the read address so the RAM output stays stable.
                    ram_adr_o = r_adr;
                end
                ACK: begin
                    ram_adr_o = r_adr;
                    wb_ack_o  = wb_cyc_i;
                    if (wb_cyc_i && r_is_read) begin
                        wb_dat_o = REG_RDATA ? r_rdata : ram_dat_i;
                    end
                end
                default: begin
                    ram_wen_o = 1'b0;
                end
            endcase
        end
    end

endmodule : wb_ram512x32_ctrl
`default_nettype wire

// File: tb/tb_wb_ram512x32_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_ram512x32_ctrl
//  Description : Self-checking bench for wb_ram512x32_ctrl. Three instances
//                cover the parameter space (fill + combinational read data,
//                fill + registered read data, no fill). Each drives a small
//                behavioural SRAM; a word-level reference memory predicts
//                every read and every handshake latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_ram512x32_ctrl;

    localparam int NI = 3;
    localparam logic [31:0] c_fill_val [NI] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'h1234_5678};
    localparam bit          c_fill_en  [NI] = '{1'b1, 1'b1, 1'b0};
    localparam bit          c_reg      [NI] = '{1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [NI];
    logic        cyc       [NI];
    logic        stb       [NI];
    logic        we        [NI];
    logic [3:0]  sel       [NI];
    logic [8:0]  adr       [NI];
    logic [31:0] dat_w     [NI];
    logic [31:0] dat_r     [NI];
    logic        ack       [NI];
    logic        init_done [NI];
    logic        ram_wen   [NI];
    logic [3:0]  ram_sel   [NI];
    logic [8:0]  ram_adr   [NI];
    logic [31:0] ram_wdat  [NI];

    logic [31:0] ref_mem [NI][512];

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [31:0] mem [512];
        logic [31:0] rd_q;

        wb_ram512x32_ctrl #(
            .FILL_EN   (c_fill_en[g]),
            .FILL_VAL  (c_fill_val[g]),
            .REG_RDATA (c_reg[g])
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst[g]),
            .wb_cyc_i    (cyc[g]),
            .wb_stb_i    (stb[g]),
            .wb_we_i     (we[g]),
            .wb_sel_i    (sel[g]),
            .wb_adr_i    (adr[g]),
            .wb_dat_i    (dat_w[g]),
            .wb_dat_o    (dat_r[g]),
            .wb_ack_o    (ack[g]),
            .init_done_o (init_done[g]),
            .ram_wen_o   (ram_wen[g]),
            .ram_sel_o   (ram_sel[g]),
            .ram_adr_o   (ram_adr[g]),
            .ram_dat_o   (ram_wdat[g]),
            .ram_dat_i   (rd_q)
        );

        // Byte-writable synchronous SRAM, read data one cycle after address.
        always @(posedge clk) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wen[g] && ram_sel[g][b]) begin
                    mem[ram_adr[g]][8*b +: 8] <= ram_wdat[g][8*b +: 8];
                end
            end
            rd_q <= mem[ram_adr[g]];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset for one edge, check the quiet outputs, then release.
    task automatic do_reset(input int k);
        rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        sel[k] = '0; adr[k] = '0; dat_w[k] = '0;
        step();
        #1;
        check_val($sformatf("i%0d rst_quiet", k),
                  {27'b0, ack[k], ram_wen[k], ram_sel[k] != 4'h0, dat_r[k] != 0, 1'b0}, 32'h0);
        check_val($sformatf("i%0d rst_init_done", k), {31'b0, init_done[k]}, {31'b0, !c_fill_en[k]});
        rst[k] = 1'b0;
    endtask

    // Observe the fill sequence for stop_at cycles; optionally present a bus
    // write at fill cycle 10 that must be stalled until IDLE.
    task automatic fill_run(input int k, input bit stall, input int stop_at);
        int bad = 0;
        for (int i = 0; i < stop_at; i++) begin
            if (stall && i == 10) begin
                cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1;
                sel[k] = 4'hF; adr[k] = 9'd77; dat_w[k] = 32'hA5A5_5A5A;
            end
            #1;
            if (ram_wen[k] !== 1'b1 || ram_sel[k] !== 4'hF || ram_adr[k] !== 9'(i) ||
                ram_wdat[k] !== c_fill_val[k] || ack[k] !== 1'b0 || dat_r[k] !== 32'h0 ||
                init_done[k] !== 1'b0) begin
                bad++;
            end
            step();
        end
        check_val($sformatf("i%0d fill_seq", k), 32'(bad), 32'h0);
        if (stop_at == 512) begin
            for (int a = 0; a < 512; a++) ref_mem[k][a] = c_fill_val[k];
            #1;
            check_val($sformatf("i%0d init_done", k), {31'b0, init_done[k]}, 32'h1);
            check_val($sformatf("i%0d idle_wen", k), {31'b0, ram_wen[k]}, {31'b0, stall});
            if (stall) begin
                check_val($sformatf("i%0d stall_noack", k), {31'b0, ack[k]}, 32'h0);
                ref_mem[k][77] = 32'hA5A5_5A5A;
                step();
                check_val($sformatf("i%0d stall_ack", k), {31'b0, ack[k]}, 32'h1);
                cyc[k] = 1'b0; stb[k] = 1'b0;
                step();
            end
        end
    endtask

    // One single-beat transfer; keep = 1 leaves cyc/stb asserted afterwards.
    task automatic xfer(input int k, input bit w, input logic [8:0] a,
                        input logic [3:0] s, input logic [31:0] d, input bit keep);
        int lat;
        int exp_lat;
        logic [31:0] exp;
        exp_lat = (!w && c_reg[k]) ? 2 : 1;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dat_w[k] = d;
        #1;
        check_val($sformatf("i%0d idle_ack_dat", k), {31'b0, ack[k] | (dat_r[k] != 0)}, 32'h0);
        if (w) begin
            check_val($sformatf("i%0d wr_ram_ctl", k),
                      {18'b0, ram_wen[k], ram_sel[k], ram_adr[k]}, {18'b0, s != 4'h0, s, a});
            check_val($sformatf("i%0d wr_ram_dat", k), ram_wdat[k], d);
        end else begin
            check_val($sformatf("i%0d rd_ram_adr", k), {22'b0, ram_wen[k], ram_adr[k]}, {23'b0, a});
        end
        exp = ref_mem[k][a];
        if (w) begin
            for (int b = 0; b < 4; b++) if (s[b]) ref_mem[k][a][8*b +: 8] = d[8*b +: 8];
        end
        step();
        lat = 1;
        while (lat <= 4) begin
            #1;
            if (ack[k] === 1'b1) break;
            check_val($sformatf("i%0d nonack_dat", k), dat_r[k], 32'h0);
            step();
            lat++;
        end
        check_val($sformatf("i%0d ack_latency", k), 32'(lat), 32'(exp_lat));
        if (ack[k] === 1'b1) begin
            check_val($sformatf("i%0d ack_data a=%0d", k, a), dat_r[k], w ? 32'h0 : exp);
        end
        if (!keep) begin
            cyc[k] = 1'b0; stb[k] = 1'b0;
        end
        step();
    endtask

    // Transfer abandoned by dropping cyc in the cycle after acceptance.
    task automatic abort_xfer(input int k, input bit w, input logic [8:0] a, input logic [31:0] d);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = 4'hF; dat_w[k] = d;
        step();
        cyc[k] = 1'b0; stb[k] = 1'b0;
        #1;
        check_val($sformatf("i%0d abort_noack", k), {31'b0, ack[k] | (dat_r[k] != 0)}, 32'h0);
        if (w) ref_mem[k][a] = d;
        step();
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            sel[k] = '0; adr[k] = '0; dat_w[k] = '0;
        end
        repeat (2) @(posedge clk);

        for (int k = 0; k < NI; k++) begin
            do_reset(k);
            if (k == 0) begin
                // Reset at fill address 200 must restart the fill from 0.
                fill_run(k, 1'b0, 200);
                do_reset(k);
                fill_run(k, 1'b1, 512);
                xfer(k, 1'b0, 9'd300, 4'hF, 32'h0, 1'b0);
                check_val("i0 fill_val_300", ref_mem[0][300], 32'hDEAD_BEEF);
            end else if (c_fill_en[k]) begin
                fill_run(k, 1'b0, 512);
                xfer(k, 1'b1, 9'd7, 4'b0101, 32'h1122_3344, 1'b0);
                xfer(k, 1'b0, 9'd7, 4'hF, 32'h0, 1'b0);
                check_val("i1 bytemask_model", ref_mem[1][7], 32'h0022_0044);
            end else begin
                for (int a = 0; a < 32; a++) xfer(k, 1'b1, 9'(a), 4'hF, $urandom, 1'b0);
            end

            // Back-to-back: cyc/stb held across 4 writes then 4 reads.
            for (int a = 0; a < 4; a++) xfer(k, 1'b1, 9'(a), 4'hF, $urandom, 1'b1);
            for (int a = 0; a < 4; a++) xfer(k, 1'b0, 9'(a), 4'hF, 32'h0, a < 3);

            abort_xfer(k, 1'b1, 9'd20, 32'hCAFE_0000 + 32'(k));
            xfer(k, 1'b0, 9'd20, 4'hF, 32'h0, 1'b0);
            abort_xfer(k, 1'b0, 9'd21, 32'h0);
            xfer(k, 1'b0, 9'd21, 4'hF, 32'h0, 1'b0);

            for (int n = 0; n < 60; n++) begin
                xfer(k, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 31)),
                     4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
            end
            cyc[k] = 1'b0; stb[k] = 1'b0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_ram512x32_ctrl
`default_nettype wire
